// File: rtl/rwd_uart_tx_if.sv
// Register write-back port of the processing unit: a write strobe plus its data word.
interface rwd_uart_tx_if #(
  parameter int unsigned DW = 16
);
  logic          we;
  logic [DW-1:0] rwd;

  // Processing unit side
  modport master (output we, output rwd);
  // Trace transmitter side
  modport slave  (input we, input rwd);
endinterface

// File: rtl/rwd_uart_tx.sv
// Register write-back tracer: queues every register write in a small FIFO and
// streams each word off-chip as 8N1 frames, most-significant byte first.
// The writer is never stalled; writes that find the FIFO full are dropped and
// recorded in the sticky ovf flag.
module rwd_uart_tx #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DIV   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  rwd_uart_tx_if.slave             wb,
  output logic                     txd,
  output logic                     busy,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned NB  = DW / 8;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned BCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BYW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e          state_q,    state_d;
  logic [BCW-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [2:0]      bit_idx_q,  bit_idx_d;
  logic [BYW-1:0]  byte_idx_q, byte_idx_d;
  logic [DW-1:0]   shreg_q,    shreg_d;
  logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]   count_q,    count_d;
  logic            ovf_q,      ovf_d;
  logic            txd_q,      txd_d;
  logic            busy_q,     busy_d;

  logic [DW-1:0]   mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic            bit_end;
  logic [7:0]      cur_byte;

  // Next-state logic for the FIFO bookkeeping, the frame sequencer and the line driver
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    pop        = 1'b0;
    bit_end    = (bit_cnt_q == BCW'(DIV - 1));

    case (state_q)
      S_IDLE: begin
        if (count_q != CW'(0)) begin
          pop        = 1'b1;
          shreg_d    = mem_q[rd_ptr_q];
          state_d    = S_START;
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (byte_idx_q == BYW'(NB - 1)) begin
            state_d = S_IDLE;
          end else begin
            // Next byte moves into the top of the shift register
            byte_idx_d = byte_idx_q + BYW'(1);
            shreg_d    = shreg_q << 8;
            state_d    = S_START;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A full FIFO still accepts a write on the edge that frees a slot
    push     = wb.we & ((count_q != CW'(DEPTH)) | pop);
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q | (wb.we & ~push);

    // Line level is computed from the next state so txd leaves a flop
    cur_byte = shreg_d[DW-1 -: 8];
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = cur_byte[bit_idx_d];
      default: txd_d = 1'b1;
    endcase

    busy_d = (count_d != CW'(0)) | (state_d != S_IDLE);
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shreg_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= wb.rwd;
    end
  end

  assign txd   = txd_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;
  assign count = count_q;

endmodule

// File: tb/tb_rwd_uart_tx.sv
// Bench for rwd_uart_tx: cycle-level reference model of queue occupancy and
// line waveform, plus an independent serial decoder on txd.
module tb_rwd_uart_tx;

  localparam int unsigned DW     = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DIV    = 4;
  localparam int unsigned NB     = DW / 8;
  localparam int          WORD_T = NB * 10 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       txd;
  logic       busy;
  logic       ovf;
  logic [2:0] count;

  rwd_uart_tx_if #(.DW(DW)) wb ();

  rwd_uart_tx #(.DW(DW), .DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .wb    (wb),
    .txd   (txd),
    .busy  (busy),
    .ovf   (ovf),
    .count (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_word;
  int            m_rem;
  logic          m_ovf;
  logic [7:0]    exp_b[$];

  // Decoder state
  logic       d_act;
  int         d_cnt;
  logic [7:0] d_byte;
  logic [7:0] d_q[$];

  typedef struct {
    logic          r;
    logic          w;
    logic [DW-1:0] d;
    int            cnt;
    logic          ovf;
    logic          busy;
    logic          txd;
  } vec_t;
  vec_t vt[9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_txd();
    int off, b, k, p;
    logic [7:0] byt;
    if (m_rem == 0) return 1'b1;
    off = WORD_T - m_rem;
    b   = off / DIV;
    k   = b / 10;
    p   = b % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    byt = 8'(m_word >> (DW - 8 - 8 * k));
    return byt[p-1];
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [DW-1:0] d);
    logic do_pop, acc;
    if (r) begin
      m_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
      exp_b.delete();
    end else begin
      do_pop = (m_rem == 0) && (m_q.size() > 0);
      acc    = w && ((m_q.size() < DEPTH) || do_pop);
      if (m_rem > 0) m_rem--;
      if (do_pop) begin
        m_word = m_q.pop_front();
        m_rem  = WORD_T;
        for (int k = 0; k < NB; k++) exp_b.push_back(8'(m_word >> (DW - 8 - 8 * k)));
      end
      if (acc) m_q.push_back(d);
      else if (w) m_ovf = 1'b1;
    end
  endtask

  task automatic decode(input logic r);
    int k;
    if (r) begin
      d_act = 1'b0;
      d_cnt = 0;
      d_q.delete();
    end else if (!d_act) begin
      if (txd == 1'b0) begin
        d_act = 1'b1;
        d_cnt = 0;
      end
    end else begin
      d_cnt++;
      if (d_cnt % DIV == DIV / 2) begin
        k = d_cnt / DIV;
        if (k >= 1 && k <= 8) d_byte[k-1] = txd;
        else if (k == 9) begin
          check("stop_bit", int'(txd), 1);
          d_q.push_back(d_byte);
          d_act = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive, advance model, then compare all outputs
  task automatic step(input logic r, input logic w, input logic [DW-1:0] d);
    rst    = r;
    wb.we  = w;
    wb.rwd = d;
    @(posedge clk);
    model_edge(r, w, d);
    #1;
    check("txd",   int'(txd),   int'(exp_txd()));
    check("busy",  int'(busy),  int'((m_q.size() != 0) || (m_rem != 0)));
    check("ovf",   int'(ovf),   int'(m_ovf));
    check("count", int'(count), m_q.size());
    decode(r);
  endtask

  task automatic drain();
    logic done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step(1'b0, 1'b0, '0);
      if (!busy && m_q.size() == 0 && m_rem == 0 && !d_act) done = 1'b1;
    end
    check("drain_timeout", int'(done), 1);
  endtask

  task automatic check_stream();
    check("stream_len", d_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < d_q.size(); i++)
      check("stream_byte", int'(d_q[i]), int'(exp_b[i]));
    d_q.delete();
    exp_b.delete();
  endtask

  initial begin
    int n;
    int maxc;
    logic hit;

    m_rem = 0; m_ovf = 1'b0; m_word = '0;
    d_act = 1'b0; d_cnt = 0; d_byte = '0;
    rst = 1'b1; wb.we = 1'b0; wb.rwd = '0;

    // Overflow sequence: reset, then 7 writes into a 4-deep FIFO
    vt[0] = '{1'b1, 1'b0, 16'd0, 0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b0, 1'b1, 16'd1, 1, 1'b0, 1'b1, 1'b1};
    vt[2] = '{1'b0, 1'b1, 16'd2, 1, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 16'd3, 2, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b1, 16'd4, 3, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b1, 16'd5, 4, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b1, 16'd6, 4, 1'b1, 1'b1, 1'b0};
    vt[7] = '{1'b0, 1'b1, 16'd7, 4, 1'b1, 1'b1, 1'b0};
    vt[8] = '{1'b0, 1'b0, 16'd0, 4, 1'b1, 1'b1, 1'b0};

    // Reset and idle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    check("rst_txd", int'(txd), 1);
    check("rst_count", int'(count), 0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, '0);

    // Single word: start latency and word time
    step(1'b0, 1'b1, 16'hA53C);
    check("cap_count", int'(count), 1);
    step(1'b0, 1'b0, '0);
    check("start_latency", int'(txd), 0);
    n = 1;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      step(1'b0, 1'b0, '0);
      n++;
      if (!busy) hit = 1'b1;
    end
    // 80-cycle frame plus the capture cycle
    check("word_time", n, WORD_T + 1);
    drain();
    check("a5_byte", (d_q.size() > 0) ? int'(d_q[0]) : -1, 8'hA5);
    check("3c_byte", (d_q.size() > 1) ? int'(d_q[1]) : -1, 8'h3C);
    check_stream();

    // Back-to-back
    maxc = 0;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b1, 16'(i));
      if (int'(count) > maxc) maxc = int'(count);
    end
    check("b2b_peak", maxc, 2);
    drain();
    check("b2b_ovf", int'(ovf), 0);
    check_stream();

    // Overflow, table driven
    foreach (vt[i]) begin
      step(vt[i].r, vt[i].w, vt[i].d);
      check("vec_count", int'(count), vt[i].cnt);
      check("vec_ovf",   int'(ovf),   int'(vt[i].ovf));
      check("vec_busy",  int'(busy),  int'(vt[i].busy));
      check("vec_txd",   int'(txd),   int'(vt[i].txd));
    end
    drain();
    check("ovf_sticky", int'(ovf), 1);
    check("ovf_words", d_q.size(), 10);
    for (int i = 0; i < 5 && 2 * i + 1 < d_q.size(); i++)
      check("ovf_word_lo", int'(d_q[2*i+1]), i + 1);
    check_stream();

    // Push on full with a simultaneous pop
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'(16'h10 + i));
    check("full_count", int'(count), DEPTH);
    for (int i = 0; i < 500 && m_rem != 0; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 16'h0015);
    check("full_pop_count", int'(count), DEPTH);
    check("full_pop_ovf", int'(ovf), 0);
    drain();
    check_stream();

    // Reset mid-frame
    step(1'b0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 1 + 3 * DIV; i++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("midrst_txd", int'(txd), 1);
    check("midrst_count", int'(count), 0);
    check("midrst_busy", int'(busy), 0);
    step(1'b0, 1'b1, 16'h5AC3);
    drain();
    check("midrst_frames", d_q.size(), 2);
    check_stream();

    // Randomized traffic at several write densities
    step(1'b1, 1'b0, '0);
    foreach (vt[j]) begin
      if (j < 3) begin
        for (int i = 0; i < 500; i++) begin
          logic w;
          w = ($urandom_range(0, 99) < (j == 0 ? 2 : (j == 1 ? 10 : 60)));
          step(1'b0, w, 16'($urandom));
        end
        drain();
        check_stream();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
